// File: rtl/tile_sprite_renderer_pkg.sv
// Shared constants and pipeline payload types for the tile/sprite renderer.
package tile_sprite_renderer_pkg;

  localparam int unsigned COLOR_W = 24;
  localparam int unsigned LATENCY = 4;

  localparam logic [COLOR_W-1:0] KEY_COLOR_DEF = 24'hFF00FF;
  localparam logic [COLOR_W-1:0] BG_COLOR_DEF  = 24'h000000;

  // Per-stage pixel control carried alongside the ROM addresses
  typedef struct packed {
    logic valid;
    logic off_map;
  } pix_ctl_t;

endpackage

// File: rtl/tile_sprite_renderer_spr.sv
// One sprite channel: frame-synchronous shadow registers, E1 rectangle hit test,
// and a delay line aligning hit and colour with the tile pipeline output stage.
module tile_sprite_renderer_spr
  import tile_sprite_renderer_pkg::*;
#(
  parameter int unsigned X_W = 9,
  parameter int unsigned Y_W = 9
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic [X_W-1:0]     i_x,
  input  logic [Y_W-1:0]     i_y,
  input  logic               i_en,
  input  logic [X_W-1:0]     i_sx,
  input  logic [Y_W-1:0]     i_sy,
  input  logic [X_W-1:0]     i_sw,
  input  logic [Y_W-1:0]     i_sh,
  input  logic [COLOR_W-1:0] i_color,
  output logic               o_hit_c,
  output logic               o_hit,
  output logic [COLOR_W-1:0] o_color
);

  localparam int unsigned DLY = LATENCY - 1;

  logic               en_q;
  logic [X_W-1:0]     sx_q, sw_q;
  logic [Y_W-1:0]     sy_q, sh_q;
  logic [COLOR_W-1:0] col_q;

  logic               en_e;
  logic [X_W-1:0]     sx_e, sw_e;
  logic [Y_W-1:0]     sy_e, sh_e;
  logic [COLOR_W-1:0] col_e;

  logic [DLY-1:0]     hit_q;
  logic [COLOR_W-1:0] dcol_q [DLY];

  // The pixel sampled on the load edge already sees the new shadow values
  assign en_e  = i_frame_start ? i_en    : en_q;
  assign sx_e  = i_frame_start ? i_sx    : sx_q;
  assign sy_e  = i_frame_start ? i_sy    : sy_q;
  assign sw_e  = i_frame_start ? i_sw    : sw_q;
  assign sh_e  = i_frame_start ? i_sh    : sh_q;
  assign col_e = i_frame_start ? i_color : col_q;

  // One extra bit on the far edge so sprites past the screen edge clip instead of wrapping
  assign o_hit_c = en_e
                && (i_x >= sx_e) && ({1'b0, i_x} < ({1'b0, sx_e} + {1'b0, sw_e}))
                && (i_y >= sy_e) && ({1'b0, i_y} < ({1'b0, sy_e} + {1'b0, sh_e}));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q  <= 1'b0;
      sx_q  <= '0;
      sy_q  <= '0;
      sw_q  <= '0;
      sh_q  <= '0;
      col_q <= '0;
      hit_q <= '0;
      for (int i = 0; i < DLY; i++) dcol_q[i] <= '0;
    end else begin
      if (i_frame_start) begin
        en_q  <= i_en;
        sx_q  <= i_sx;
        sy_q  <= i_sy;
        sw_q  <= i_sw;
        sh_q  <= i_sh;
        col_q <= i_color;
      end
      hit_q     <= {hit_q[DLY-2:0], o_hit_c};
      dcol_q[0] <= col_e;
      for (int i = 1; i < DLY; i++) dcol_q[i] <= dcol_q[i-1];
    end
  end

  assign o_hit   = hit_q[DLY-1];
  assign o_color = dcol_q[DLY-1];

endmodule

// File: rtl/tile_sprite_renderer.sv
// Tile-map background renderer with prioritised sprite overlay, colour-key
// transparency and per-frame sprite collision flags; 4-cycle fixed latency.
module tile_sprite_renderer
  import tile_sprite_renderer_pkg::*;
#(
  parameter int unsigned X_W       = 9,
  parameter int unsigned Y_W       = 9,
  parameter int unsigned TILE_LOG2 = 2,
  parameter int unsigned MAP_COLS  = 120,
  parameter int unsigned MAP_ROWS  = 68,
  parameter int unsigned MAP_AW    = 13,
  parameter int unsigned MAP_DW    = 6,
  parameter int unsigned TILE_AW   = MAP_DW + 2*TILE_LOG2,
  parameter int unsigned N_SPR     = 3,
  parameter logic [COLOR_W-1:0] KEY_COLOR = KEY_COLOR_DEF,
  parameter logic [COLOR_W-1:0] BG_COLOR  = BG_COLOR_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_frame_start,
  input  logic                     i_valid,
  input  logic [X_W-1:0]           i_x,
  input  logic [Y_W-1:0]           i_y,
  output logic [MAP_AW-1:0]        o_map_addr,
  input  logic [MAP_DW-1:0]        i_map_data,
  output logic [TILE_AW-1:0]       o_tile_addr,
  input  logic [COLOR_W-1:0]       i_tile_data,
  input  logic [N_SPR-1:0]         i_spr_en,
  input  logic [N_SPR*X_W-1:0]     i_spr_x,
  input  logic [N_SPR*Y_W-1:0]     i_spr_y,
  input  logic [N_SPR*X_W-1:0]     i_spr_w,
  input  logic [N_SPR*Y_W-1:0]     i_spr_h,
  input  logic [N_SPR*COLOR_W-1:0] i_spr_color,
  output logic                     o_valid,
  output logic [COLOR_W-1:0]       o_color,
  output logic [N_SPR-1:0]         o_collision
);

  localparam int unsigned TX_W  = X_W - TILE_LOG2;
  localparam int unsigned TY_W  = Y_W - TILE_LOG2;
  localparam int unsigned LOW_W = 2*TILE_LOG2;

  logic [N_SPR-1:0]   hit_c, hit;
  logic [COLOR_W-1:0] spr_col [N_SPR];

  for (genvar k = 0; k < N_SPR; k++) begin : g_spr
    tile_sprite_renderer_spr #(.X_W(X_W), .Y_W(Y_W)) u_spr (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_frame_start (i_frame_start),
      .i_x           (i_x),
      .i_y           (i_y),
      .i_en          (i_spr_en[k]),
      .i_sx          (i_spr_x[k*X_W +: X_W]),
      .i_sy          (i_spr_y[k*Y_W +: Y_W]),
      .i_sw          (i_spr_w[k*X_W +: X_W]),
      .i_sh          (i_spr_h[k*Y_W +: Y_W]),
      .i_color       (i_spr_color[k*COLOR_W +: COLOR_W]),
      .o_hit_c       (hit_c[k]),
      .o_hit         (hit[k]),
      .o_color       (spr_col[k])
    );
  end

  logic [TX_W-1:0]    tx_c;
  logic [TY_W-1:0]    ty_c;
  logic               off_c;
  logic [MAP_AW-1:0]  map_addr_d, map_addr_q;
  logic [LOW_W-1:0]   low1_q;
  logic [TILE_AW-1:0] tile_addr_q;
  logic [COLOR_W-1:0] tile_q;
  pix_ctl_t           s1_q, s2_q, s3_q;
  logic [COLOR_W-1:0] color_d, color_q;
  logic               valid_q;
  logic [N_SPR-1:0]   coll_c, acc_d, acc_q, coll_d, coll_q;

  assign tx_c       = i_x[X_W-1:TILE_LOG2];
  assign ty_c       = i_y[Y_W-1:TILE_LOG2];
  assign off_c      = (32'(tx_c) >= MAP_COLS) || (32'(ty_c) >= MAP_ROWS);
  assign map_addr_d = off_c ? '0 : MAP_AW'(32'(ty_c) * MAP_COLS + 32'(tx_c));

  // Lowest index wins, so sweep from the highest index downwards
  always_comb begin
    color_d = '0;
    if (s3_q.valid) begin
      color_d = (s3_q.off_map || (tile_q == KEY_COLOR)) ? BG_COLOR : tile_q;
      for (int k = N_SPR-1; k >= 0; k--) begin
        if (hit[k]) color_d = spr_col[k];
      end
    end
  end

  // A hit on the frame-start edge belongs to the new frame's accumulator
  always_comb begin
    coll_c = '0;
    for (int k = 0; k < N_SPR; k++) begin
      coll_c[k] = hit_c[k] && (|(hit_c & ~(N_SPR'(1) << k)));
    end
    acc_d  = (i_frame_start ? '0 : acc_q) | (i_valid ? coll_c : '0);
    coll_d = i_frame_start ? acc_q : coll_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      map_addr_q  <= '0;
      low1_q      <= '0;
      tile_addr_q <= '0;
      tile_q      <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      color_q     <= '0;
      valid_q     <= 1'b0;
      acc_q       <= '0;
      coll_q      <= '0;
    end else begin
      map_addr_q  <= map_addr_d;
      low1_q      <= {i_y[TILE_LOG2-1:0], i_x[TILE_LOG2-1:0]};
      s1_q        <= '{valid: i_valid, off_map: off_c};
      tile_addr_q <= {i_map_data, low1_q};
      s2_q        <= s1_q;
      tile_q      <= i_tile_data;
      s3_q        <= s2_q;
      color_q     <= color_d;
      valid_q     <= s3_q.valid;
      acc_q       <= acc_d;
      coll_q      <= coll_d;
    end
  end

  assign o_map_addr  = map_addr_q;
  assign o_tile_addr = tile_addr_q;
  assign o_color     = color_q;
  assign o_valid     = valid_q;
  assign o_collision = coll_q;

endmodule
